// File: rtl/resp_timer.sv
`default_nettype none
// ============================================================================
// Module   : resp_timer
// Purpose  : Measures the target's reply latency in clk cycles. A rising edge
//            on the (delayed) arm level starts a measurement; the first
//            falling edge on the synchronized reply line ends it. If no reply
//            arrives within TIMEOUT cycles, a timeout strobe is issued instead.
// Revision : 1.0 - initial release
// ============================================================================
module resp_timer #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             din,
    output logic             busy,
    output logic             time_valid,
    output logic [CNT_W-1:0] time_cycles,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_TIMING = 1'b1
    } state_t;

    // Input conditioning: din and arm see the same number of flops so that
    // the measured interval equals the interval between the raw input edges.
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_din_hist;
    logic [SYNC_STAGES-1:0] r_arm_dly;
    logic                   r_arm_hist;
    logic                   r_arm_rise;
    logic                   r_din_fall;
    logic                   w_arm_rise;
    logic                   w_din_fall;

    // Measurement core.
    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_next;
    logic [CNT_W-1:0]       w_count_inc;
    logic                   r_done;
    logic                   w_done_next;
    logic [CNT_W-1:0]       r_result;
    logic [CNT_W-1:0]       w_result_next;
    logic                   r_timeout;
    logic                   w_timeout_next;

    assign w_arm_rise  = r_arm_dly[SYNC_STAGES-1] & ~r_arm_hist;
    assign w_din_fall  = ~r_din_sync[SYNC_STAGES-1] & r_din_hist;
    assign w_count_inc = r_count + CNT_W'(1);

    // Synchronizer, arm delay line and registered edge strobes; reset to the
    // idle levels so no edge is seen right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_sync <= '1;
            r_din_hist <= 1'b1;
            r_arm_dly  <= '0;
            r_arm_hist <= 1'b0;
            r_arm_rise <= 1'b0;
            r_din_fall <= 1'b0;
        end else begin
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], din};
            r_din_hist <= r_din_sync[SYNC_STAGES-1];
            r_arm_dly  <= {r_arm_dly[SYNC_STAGES-2:0], arm};
            r_arm_hist <= r_arm_dly[SYNC_STAGES-1];
            r_arm_rise <= w_arm_rise;
            r_din_fall <= w_din_fall;
        end
    end

    // FSM state, counter and decision registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_done    <= w_done_next;
            r_result  <= w_result_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Next-state logic: a reply edge takes priority over the timeout check,
    // and edges that arrive outside TIMING are simply dropped.
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_done_next    = 1'b0;
        w_result_next  = r_result;
        w_timeout_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_arm_rise) begin
                    w_count_next = '0;
                    w_state_next = ST_TIMING;
                end
            end
            ST_TIMING: begin
                w_count_next = w_count_inc;
                if (r_din_fall) begin
                    w_result_next = w_count_inc;
                    w_done_next   = 1'b1;
                    w_state_next  = ST_IDLE;
                end else if (w_count_inc == c_TIMEOUT) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output register: busy, time_valid and time_cycles move together one
    // cycle after the FSM decision; time_cycles holds its value on timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            time_valid  <= 1'b0;
            time_cycles <= '0;
        end else begin
            busy       <= (r_state == ST_TIMING);
            time_valid <= r_done;
            if (r_done) begin
                time_cycles <= r_result;
            end
        end
    end

    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_resp_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_resp_timer
// Purpose  : Directed bench for resp_timer. Stimulus pushes expected results
//            into a scoreboard queue; a monitor pops and compares whenever
//            the DUT raises time_valid or timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_resp_timer;

    localparam int S = 2;
    localparam int T = 1000;
    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         arm;
    logic         din;
    logic         busy;
    logic         time_valid;
    logic [W-1:0] time_cycles;
    logic         timeout;

    resp_timer #(
        .CNT_W       (W),
        .TIMEOUT     (T),
        .SYNC_STAGES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .din         (din),
        .busy        (busy),
        .time_valid  (time_valid),
        .time_cycles (time_cycles),
        .timeout     (timeout)
    );

    typedef struct {
        bit is_to;
        int value;
        int at_edge;
        int tol;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter: at a negedge, cyc is the number of the last posedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp, input int tol);
        longint d;
        n_cmp++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at edge %0d", name, act, exp, tol, cyc);
        end
    endtask

    task automatic push(input bit is_to, input int value, input int at_edge, input int tol);
        exp_t e;
        e.is_to   = is_to;
        e.value   = value;
        e.at_edge = at_edge;
        e.tol     = tol;
        sb_q.push_back(e);
    endtask

    // Return at the negedge just before posedge e, so inputs set now are
    // first sampled at edge e.
    task automatic goto_edge(input int e);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic arm_at(output int a);
        @(negedge clk);
        arm = 1'b1;
        a   = cyc + 1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected events still pending after %0d cycles, required 0", sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compares every result/timeout strobe against the scoreboard.
    initial begin : monitor
        bit   prev_busy;
        int   busy_start;
        exp_t e;
        prev_busy  = 1'b0;
        busy_start = 0;
        forever begin
            @(negedge clk);
            if (busy && !prev_busy) busy_start = cyc;
            if (time_valid || timeout) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: time_valid=%0b timeout=%0b at edge %0d, expected none", time_valid, timeout, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("strobe_kind", {time_valid, timeout}, e.is_to ? 2'b01 : 2'b10, 0);
                    chk("strobe_edge", cyc, e.at_edge, e.tol);
                    if (!e.is_to) begin
                        chk("time_cycles", time_cycles, e.value, e.tol);
                        chk("busy_length", cyc - busy_start, e.value, e.tol);
                        chk("busy_low_at_valid", busy, 0, 0);
                    end
                end
            end
            prev_busy = busy;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int a;
        int n;
        rst = 1'b1;
        arm = 1'b0;
        din = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(3);
        chk("reset_busy", busy, 0, 0);
        chk("reset_time_valid", time_valid, 0, 0);
        chk("reset_timeout", timeout, 0, 0);
        chk("reset_time_cycles", time_cycles, 0, 0);

        // Basic measurement of 100 cycles, then arm held high: no rerun.
        goto_edge(10);
        arm = 1'b1;
        a   = 10;
        push(0, 100, a + 100 + S + 2, 0);
        goto_edge(a + 100); din = 1'b0;
        goto_edge(a + 110); din = 1'b1;
        drain(200);
        idle(60);
        arm = 1'b0;
        idle(10);

        // Minimum value: fall sampled on the edge right after arming.
        arm_at(a);
        push(0, 1, a + 1 + S + 2, 0);
        goto_edge(a + 1); din = 1'b0;
        goto_edge(a + 5); din = 1'b1;
        drain(50);
        arm = 1'b0;
        idle(10);

        // Fall on the arming edge is ignored; the next fall at A+50 counts.
        @(negedge clk);
        arm = 1'b1;
        din = 1'b0;
        a   = cyc + 1;
        push(0, 50, a + 50 + S + 2, 0);
        goto_edge(a + 10); din = 1'b1;
        goto_edge(a + 50); din = 1'b0;
        goto_edge(a + 55); din = 1'b1;
        drain(100);
        arm = 1'b0;
        idle(10);

        // Timeout with din held high; previous result must be retained.
        arm_at(a);
        push(1, 0, a + S + 1 + T, 0);
        drain(T + 50);
        idle(3);
        chk("time_cycles_kept_after_timeout", time_cycles, 50, 0);
        chk("busy_after_timeout", busy, 0, 0);
        arm = 1'b0;
        idle(10);

        // Arm toggle during TIMING does not disturb the result.
        arm_at(a);
        push(0, 40, a + 40 + S + 2, 0);
        goto_edge(a + 10); arm = 1'b0;
        goto_edge(a + 15); arm = 1'b1;
        goto_edge(a + 40); din = 1'b0;
        goto_edge(a + 45); din = 1'b1;
        drain(100);
        idle(20);
        arm = 1'b0;
        idle(10);

        // Re-arm after dropping arm yields a fresh result.
        arm_at(a);
        push(0, 25, a + 25 + S + 2, 0);
        goto_edge(a + 25); din = 1'b0;
        goto_edge(a + 30); din = 1'b1;
        drain(100);
        arm = 1'b0;
        idle(10);

        // Reset 30 cycles into TIMING: no strobe, everything back to zero.
        arm_at(a);
        goto_edge(a + S + 1 + 30);
        rst = 1'b1;
        arm = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(10);
        din = 1'b0;
        idle(5);
        din = 1'b1;
        idle(20);
        chk("post_reset_busy", busy, 0, 0);
        chk("post_reset_time_valid", time_valid, 0, 0);
        chk("post_reset_timeout", timeout, 0, 0);
        chk("post_reset_time_cycles", time_cycles, 0, 0);

        // din already low when armed: only the later fall ends the run.
        din = 1'b0;
        idle(5);
        arm_at(a);
        push(0, 70, a + 70 + S + 2, 0);
        goto_edge(a + 20); din = 1'b1;
        goto_edge(a + 70); din = 1'b0;
        goto_edge(a + 75); din = 1'b1;
        drain(100);
        arm = 1'b0;
        idle(10);

        // Asynchronous fall at a random phase inside the target cycle.
        for (int i = 0; i < 3; i++) begin
            arm_at(a);
            n = $urandom_range(5, 60);
            push(0, n, a + n + S + 2, 1);
            goto_edge(a + n - 1);
            @(posedge clk);
            #($urandom_range(1, 9));
            din = 1'b0;
            idle(3);
            din = 1'b1;
            drain(100);
            arm = 1'b0;
            idle(10);
        end

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
